// File: rtl/audio_pkg.sv
// Shared constants and sizing helper for the audio DAC serializer.
package audio_pkg;
  localparam int SAMPLE_W_DEF = 24;
  localparam logic MODE_LJ  = 1'b0;
  localparam logic MODE_I2S = 1'b1;

  // Width of a counter spanning 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/audio_bclk_div.sv
// BCLK divider: toggles aud_bclk every BCLK_HALF clk cycles, with rise/fall strobes.
module audio_bclk_div
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = 4
) (
  input  logic clk,
  input  logic reset,
  output logic aud_bclk,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_w(BCLK_HALF);

  logic [CW-1:0] cnt;
  logic          tc;

  // Strobes mark the cycle whose closing edge performs the toggle.
  assign tc   = (cnt == CW'(BCLK_HALF - 1));
  assign rise = tc && !aud_bclk;
  assign fall = tc && aud_bclk;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      aud_bclk <= 1'b0;
    end else if (tc) begin
      cnt      <= '0;
      aud_bclk <= ~aud_bclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/audio_dac_serializer.sv
// Mono sample stream to codec DAC serial bus (LJ or I2S), one-entry input buffer.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_HALF = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i2s_mode,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                aud_bclk,
  output logic                aud_daclrck,
  output logic                aud_dacdat,
  output logic                frame_start,
  output logic                underrun
);
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int IW         = cnt_w(FRAME_BITS);

  logic                rise, fall;
  logic [IW-1:0]       bit_idx, next_idx;
  logic [SAMPLE_W-1:0] buf_q, frame_q, frame_next, shifted;
  logic                buf_valid, mode_q, mode_next, load, xfer, dat_next;
  int                  pos;

  audio_bclk_div #(.BCLK_HALF(BCLK_HALF)) u_div (
    .clk      (clk),
    .reset    (reset),
    .aud_bclk (aud_bclk),
    .rise     (rise),
    .fall     (fall)
  );

  assign load        = fall && (bit_idx == IW'(FRAME_BITS - 1));
  assign in_ready    = !buf_valid || load;
  assign xfer        = in_valid && in_ready;
  assign frame_start = load;
  assign underrun    = load && !buf_valid;

  // Next-bit data is computed from the post-load frame and mode, so the
  // first bit of a new frame already reflects the freshly loaded sample.
  always_comb begin
    next_idx   = (bit_idx == IW'(FRAME_BITS - 1)) ? '0 : bit_idx + 1'b1;
    frame_next = load ? (buf_valid ? buf_q : frame_q) : frame_q;
    mode_next  = load ? i2s_mode : mode_q;
    pos        = int'(next_idx) % SLOT_BITS;
    shifted    = '0;
    dat_next   = 1'b0;
    if (mode_next == MODE_I2S) begin
      if (pos >= 1 && pos <= SAMPLE_W) begin
        shifted  = frame_next << (pos - 1);
        dat_next = shifted[SAMPLE_W-1];
      end
    end else if (pos < SAMPLE_W) begin
      shifted  = frame_next << pos;
      dat_next = shifted[SAMPLE_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx     <= IW'(FRAME_BITS - 1);
      aud_daclrck <= 1'b1;
      aud_dacdat  <= 1'b0;
      frame_q     <= '0;
      mode_q      <= MODE_LJ;
      buf_q       <= '0;
      buf_valid   <= 1'b0;
    end else begin
      if (fall) begin
        bit_idx     <= next_idx;
        aud_daclrck <= (int'(next_idx) >= SLOT_BITS);
        aud_dacdat  <= dat_next;
        frame_q     <= frame_next;
        mode_q      <= mode_next;
      end
      // A push on the load cycle refills the buffer the load just drained.
      if (xfer) begin
        buf_q     <= in_sample;
        buf_valid <= 1'b1;
      end else if (load) begin
        buf_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer at BCLK_HALF=2, SLOT_BITS=32 (256-cycle frames).
module tb_audio_dac_serializer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i2s_mode = 1'b0;
  logic [23:0] in_sample = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun;

  int checks = 0;
  int errors = 0;

  audio_dac_serializer #(.SAMPLE_W(24), .SLOT_BITS(32), .BCLK_HALF(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .i2s_mode    (i2s_mode),
    .in_sample   (in_sample),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .aud_bclk    (aud_bclk),
    .aud_daclrck (aud_daclrck),
    .aud_dacdat  (aud_dacdat),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  // Left slot in the upper 32 bits, right slot in the lower, MSB = first bit on the wire.
  localparam logic [63:0] LR_EXP = 64'h00000000_FFFFFFFF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts cycles (the current one is 1) until frame_start, bounded.
  task automatic wait_frame(output int n);
    n = 1;
    while (!frame_start && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Called in a load cycle; returns in the next load cycle.
  task automatic capture(input int toggle_k, input logic nv, input logic [23:0] ns,
                         output logic [63:0] dat, output logic [63:0] lr, output int rdy);
    rdy = 0;
    dat = '0;
    lr  = '0;
    for (int k = 0; k < 64; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (k == 0 && c == 0) begin
          in_valid  = nv;
          in_sample = ns;
        end
        if (c == 0) begin
          dat[63-k] = aud_dacdat;
          lr[63-k]  = aud_daclrck;
          if (k == toggle_k) i2s_mode = ~i2s_mode;
        end
        if (!(k == 63 && c == 3)) rdy += int'(in_ready);
      end
    end
  endtask

  initial begin
    int          n, seen_at, rdy;
    logic [7:0]  bvec;
    logic        rdy_mid;
    logic [63:0] dat, lr;

    // Reset state
    repeat (5) begin @(posedge clk); #1; end
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_lrck", 64'(aud_daclrck), 64'd1);
    chk("rst_bclk", 64'(aud_bclk), 64'd0);
    chk("rst_dat", 64'(aud_dacdat), 64'd0);
    chk("rst_pulses", 64'({frame_start, underrun}), 64'd0);
    reset = 1'b0;

    // First load: 4th cycle counting the release cycle, buffer empty
    wait_frame(n);
    chk("first_fs_latency", 64'(n), 64'd4);
    chk("first_underrun", 64'(underrun), 64'd1);
    chk("load_ready", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_sample = 24'hA50F3C;
    seen_at = 0;
    bvec    = '0;
    rdy_mid = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk); #1;
      if (i == 1) in_valid = 1'b0;
      if (i <= 8) bvec = {bvec[6:0], aud_bclk};
      if (i == 128) rdy_mid = in_ready;
      if (frame_start && seen_at == 0) seen_at = i;
    end
    chk("bclk_pattern", 64'(bvec), 64'h33);
    chk("frame_period", 64'(seen_at), 64'd256);
    chk("ready_low_full", 64'(rdy_mid), 64'd0);

    // Left-justified A50F3C
    chk("lj_underrun", 64'(underrun), 64'd0);
    capture(-1, 1'b0, 24'h0, dat, lr, rdy);
    chk("lj_data", dat, 64'hA50F3C00_A50F3C00);
    chk("lj_lrck", lr, LR_EXP);

    // I2S repeat of A50F3C; mode flipped back mid-frame must not matter yet
    chk("i2s_underrun", 64'(underrun), 64'd1);
    i2s_mode = 1'b1;
    capture(20, 1'b0, 24'h0, dat, lr, rdy);
    chk("i2s_data", dat, 64'h52879E00_52879E00);
    chk("i2s_lrck", lr, LR_EXP);

    // Backpressure chain 1,2,3 then 123456, valid held high
    chk("bp_fs", 64'(frame_start), 64'd1);
    in_valid  = 1'b1;
    in_sample = 24'h000001;
    capture(-1, 1'b1, 24'h000002, dat, lr, rdy);
    chk("toggle_deferred_lj", dat, 64'hA50F3C00_A50F3C00);
    chk("bp_ready_f4", 64'(rdy), 64'd0);
    chk("bp_load_ready", 64'(in_ready), 64'd1);
    chk("bp_underrun5", 64'(underrun), 64'd0);
    capture(-1, 1'b1, 24'h000003, dat, lr, rdy);
    chk("bp_data1", dat, 64'h00000100_00000100);
    chk("bp_ready_f5", 64'(rdy), 64'd0);
    capture(-1, 1'b1, 24'h123456, dat, lr, rdy);
    chk("bp_data2", dat, 64'h00000200_00000200);
    capture(-1, 1'b0, 24'h0, dat, lr, rdy);
    chk("bp_data3", dat, 64'h00000300_00000300);
    chk("bp_ready_f7", 64'(rdy), 64'd0);

    // Underrun repeat of 123456
    chk("ur_underrun8", 64'(underrun), 64'd0);
    capture(-1, 1'b0, 24'h0, dat, lr, rdy);
    chk("ur_data8", dat, 64'h12345600_12345600);
    chk("ur_ready_empty", 64'(rdy), 64'd255);
    chk("ur_underrun9", 64'(underrun), 64'd1);
    capture(-1, 1'b0, 24'h0, dat, lr, rdy);
    chk("ur_data9", dat, 64'h12345600_12345600);
    chk("ur_underrun10", 64'(underrun), 64'd1);
    capture(-1, 1'b0, 24'h0, dat, lr, rdy);
    chk("ur_data10", dat, 64'h12345600_12345600);
    chk("ur_underrun11", 64'(underrun), 64'd1);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_sample = 24'h0ABCDE;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_frame(n);
    chk("push_gap", 64'(n), 64'd255);
    chk("push_underrun", 64'(underrun), 64'd0);
    capture(-1, 1'b0, 24'h0, dat, lr, rdy);
    chk("push_data", dat, 64'h0ABCDE00_0ABCDE00);

    // Reset at bit index 40 with a sample waiting in the buffer
    in_valid  = 1'b1;
    in_sample = 24'h777777;
    repeat (161) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    chk("mid_lrck", 64'(aud_daclrck), 64'd1);
    chk("mid_buf_full", 64'(in_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_outs", 64'({aud_bclk, aud_dacdat, aud_daclrck, in_ready}), 64'b0011);
    wait_frame(n);
    chk("mid_fs_latency", 64'(n), 64'd4);
    chk("mid_underrun", 64'(underrun), 64'd1);
    capture(-1, 1'b0, 24'h0, dat, lr, rdy);
    chk("mid_discarded", dat, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
